pvt_gpi_mc: RTL

Multi-chain serial GPIO input deserializer for the CPLD. It drives a shared serial clock and parallel-load strobe to NUM_CH external parallel-in/serial-out shift-register chains, each with TOTAL_BIT_COUNT bits. All chains are sampled concurrently. Each bit is frame-to-frame glitch filtered, and the block raises a maskable sticky change interrupt toward the host register block.

---
 rtl/pvt_gpi_pkg.sv | 15 +
 rtl/pvt_gpi_filter.sv | 57 +++++
 rtl/pvt_gpi_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pvt_gpi_pkg.sv
// pvt_gpi_pkg: shared types for the multi-chain serial GPIO input deserializer.
// Holds the frame state encoding and the parallel-load length.
package pvt_gpi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } gpi_state_t;

    localparam int LOAD_TICKS = 2;
    localparam int LOAD_CNT_W = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS) : 1;

endpackage

// File: rtl/pvt_gpi_filter.sv
// pvt_gpi_filter: per-bit frame-to-frame glitch filter with sticky change flag.
// A bit follows its raw value only after FILTER_DEPTH identical frames.
module pvt_gpi_filter
    import pvt_gpi_pkg::*;
#(
    parameter int   FILTER_DEPTH = 2,
    parameter logic DEFAULT_BIT  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic raw,
    input  logic int_mask,
    input  logic change_clr,
    output logic par_bit,
    output logic change_pend
);

    localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_DEPTH - 1);

    logic          raw_prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          take;
    logic          set;

    // Count saturates so a long-stable bit keeps refreshing par_bit.
    always_comb begin
        cnt_nxt = '0;
        if (raw == raw_prev) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    assign take = update && (cnt_nxt == CNT_MAX);
    assign set  = take && (raw != par_bit) && int_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_prev    <= DEFAULT_BIT;
            cnt         <= '0;
            par_bit     <= DEFAULT_BIT;
            change_pend <= 1'b0;
        end else begin
            if (update) begin
                raw_prev <= raw;
                cnt      <= cnt_nxt;
            end
            if (take) begin
                par_bit <= raw;
            end
            change_pend <= set | (change_pend & ~change_clr);
        end
    end

endmodule

// File: rtl/pvt_gpi_mc.sv
// pvt_gpi_mc: drives serclk/load to NUM_CH PISO chains, captures all chains
// concurrently and filters each bit before presenting it to the host.
module pvt_gpi_mc
    import pvt_gpi_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int TOTAL_BIT_COUNT = 64,
    parameter logic [NUM_CH*TOTAL_BIT_COUNT-1:0] DEFAULT_STATE = '0,
    parameter int FILTER_DEPTH    = 2,
    parameter int NUMBER_OF_COUNTER_BITS = $clog2(TOTAL_BIT_COUNT)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clk_ena,
    input  logic                              scan_en,
    input  logic [NUM_CH-1:0]                 sdi,
    input  logic [NUM_CH*TOTAL_BIT_COUNT-1:0] int_mask,
    input  logic [NUM_CH*TOTAL_BIT_COUNT-1:0] change_clr,
    output logic                              serclk_out,
    output logic                              par_load_out_n,
    output logic [NUM_CH*TOTAL_BIT_COUNT-1:0] par_data,
    output logic [NUM_CH*TOTAL_BIT_COUNT-1:0] change_pend,
    output logic                              irq,
    output logic                              frame_done
);

    localparam int W = NUM_CH * TOTAL_BIT_COUNT;
    localparam logic [NUMBER_OF_COUNTER_BITS-1:0] LAST_BIT =
        NUMBER_OF_COUNTER_BITS'(TOTAL_BIT_COUNT - 1);
    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(LOAD_TICKS - 1);

    gpi_state_t                        state;
    gpi_state_t                        state_d;
    logic                              serclk_d;
    logic [LOAD_CNT_W-1:0]             load_cnt;
    logic [LOAD_CNT_W-1:0]             load_cnt_d;
    logic [NUMBER_OF_COUNTER_BITS-1:0] bit_idx;
    logic [NUMBER_OF_COUNTER_BITS-1:0] bit_idx_d;
    logic                              capture;
    logic                              update;
    logic [W-1:0]                      raw;

    assign update = (state == UPDATE);

    always_comb begin
        state_d    = state;
        serclk_d   = serclk_out;
        load_cnt_d = load_cnt;
        bit_idx_d  = bit_idx;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                serclk_d   = 1'b0;
                load_cnt_d = '0;
                if (clk_ena && scan_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                serclk_d  = 1'b0;
                bit_idx_d = '0;
                if (clk_ena) begin
                    if (load_cnt == LOAD_LAST) begin
                        state_d = SHIFT;
                    end else begin
                        load_cnt_d = load_cnt + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (clk_ena) begin
                    serclk_d = ~serclk_out;
                    if (!serclk_out) begin
                        capture = 1'b1;
                    end else if (bit_idx == LAST_BIT) begin
                        state_d = UPDATE;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            UPDATE: begin
                load_cnt_d = '0;
                state_d    = scan_en ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load strobe registered from the next state so it is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            serclk_out     <= 1'b0;
            par_load_out_n <= 1'b1;
            load_cnt       <= '0;
            bit_idx        <= '0;
            frame_done     <= 1'b0;
            irq            <= 1'b0;
        end else begin
            state          <= state_d;
            serclk_out     <= serclk_d;
            par_load_out_n <= (state_d != LOAD);
            load_cnt       <= load_cnt_d;
            bit_idx        <= bit_idx_d;
            frame_done     <= update;
            irq            <= |change_pend;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [TOTAL_BIT_COUNT-1:0] raw_ch;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                raw_ch <= DEFAULT_STATE[c*TOTAL_BIT_COUNT +: TOTAL_BIT_COUNT];
            end else if (capture) begin
                raw_ch[bit_idx] <= sdi[c];
            end
        end

        assign raw[c*TOTAL_BIT_COUNT +: TOTAL_BIT_COUNT] = raw_ch;
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        pvt_gpi_filter #(
            .FILTER_DEPTH (FILTER_DEPTH),
            .DEFAULT_BIT  (DEFAULT_STATE[i])
        ) u_filt (
            .clk         (clk),
            .reset_n     (reset_n),
            .update      (update),
            .raw         (raw[i]),
            .int_mask    (int_mask[i]),
            .change_clr  (change_clr[i]),
            .par_bit     (par_data[i]),
            .change_pend (change_pend[i])
        );
    end

endmodule
